// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states
//   rr_next     : first set bit of valid searching upward from last+1, wrapping
//                 modulo num_req; returns last when nothing is set
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned RR_MAX_REQ = 32;
  localparam int unsigned RR_IDX_W   = 5;

  function automatic int unsigned rr_next(input logic [RR_MAX_REQ-1:0] valid,
                                          input int unsigned            last,
                                          input int unsigned            num_req);
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    rr_next = last;
    found   = 1'b0;
    // Offset 1 first so the previous holder is examined last.
    for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
      idx = RR_IDX_W'((last + k) % num_req);
      if (!found && (k <= num_req) && valid[idx]) begin
        rr_next = 32'(idx);
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req       : per-producer request vector
//   last      : index of the most recently released producer
//   winner    : next producer to grant (meaningful only when any_valid)
//   any_valid : at least one request is set
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  always_comb begin
    winner    = IDX_W'(rr_next(RR_MAX_REQ'(req), 32'(last), NUM_REQ));
    any_valid = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between NUM_REQ producers with round-robin
// arbitration and burst hold of up to MAX_BURST accepted beats per grant.
//   clk, rstn    : clock, asynchronous active-low reset
//   req_valid    : per-producer data valid
//   req_data     : producer i data in bits [i*WIDTH +: WIDTH]
//   req_ready    : per-producer accept
//   fifo_full    : FIFO full flag (back-pressure)
//   fifo_w_en    : FIFO write enable
//   fifo_w_data  : FIFO write data
//   grant_valid  : a producer currently holds the port
//   grant_id     : index of the holding producer
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_REQ),
  localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_w_en,
  output logic [WIDTH-1:0]         fifo_w_data,
  output logic                     grant_valid,
  output logic [IDX_W-1:0]         grant_id
);

  arb_state_t       state, state_d;
  logic [IDX_W-1:0] grant_id_d;
  logic             grant_valid_d;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_d;
  logic [IDX_W-1:0] last_grant, last_grant_d;
  logic [IDX_W-1:0] rr_winner;
  logic             rr_any;
  logic             xfer;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req       (req_valid),
    .last      (last_grant),
    .winner    (rr_winner),
    .any_valid (rr_any)
  );

  // State register; last_grant resets to the top index so producer 0 wins first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      beat_cnt    <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state       <= state_d;
      grant_id    <= grant_id_d;
      grant_valid <= grant_valid_d;
      beat_cnt    <= beat_cnt_d;
      last_grant  <= last_grant_d;
    end
  end

  // Next state and port muxing; outputs follow the registered holder.
  always_comb begin
    state_d       = state;
    grant_id_d    = grant_id;
    grant_valid_d = grant_valid;
    beat_cnt_d    = beat_cnt;
    last_grant_d  = last_grant;
    req_ready     = '0;
    fifo_w_en     = 1'b0;
    fifo_w_data   = '0;
    xfer          = 1'b0;

    case (state)
      IDLE: begin
        if (rr_any) begin
          grant_id_d    = rr_winner;
          grant_valid_d = 1'b1;
          beat_cnt_d    = '0;
          state_d       = GRANT;
        end
      end

      GRANT: begin
        xfer                = req_valid[grant_id] && !fifo_full;
        req_ready[grant_id] = !fifo_full;
        fifo_w_en           = xfer;
        fifo_w_data         = req_data[32'(grant_id)*WIDTH +: WIDTH];

        // Idle producer or final beat of the burst hands the port back.
        if (!req_valid[grant_id] ||
            (xfer && (beat_cnt == CNT_W'(MAX_BURST - 1)))) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          last_grant_d  = grant_id;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned BURST = 4;

  logic          clk;
  logic          rstn;
  logic [3:0]    req_valid;
  logic [31:0]   req_data;
  logic [3:0]    req_ready;
  logic          fifo_full;
  logic          fifo_w_en;
  logic [7:0]    fifo_w_data;
  logic          grant_valid;
  logic [1:0]    grant_id;

  int errors;
  int checks;
  logic [15:0] obs;
  logic [15:0] expv;

  fifo_wr_arbiter #(.NUM_REQ(NREQ), .WIDTH(W), .MAX_BURST(BURST)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_w_en   (fifo_w_en),
    .fifo_w_data (fifo_w_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  // grant_id is only meaningful while grant_valid is set.
  function automatic logic [15:0] obs_vec();
    return {grant_valid, (grant_valid ? grant_id : 2'd0), req_ready, fifo_w_en, fifo_w_data};
  endfunction

  function automatic logic [15:0] exp_vec(input logic gv, input logic [1:0] gid,
                                          input logic [3:0] rdy, input logic wen,
                                          input logic [7:0] d);
    return {gv, gid, rdy, wen, d};
  endfunction

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic pulse_reset();
    req_valid = '0;
    fifo_full = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(negedge clk);
    #1;
    obs = obs_vec(); expv = exp_vec(1'b0, 2'd0, 4'd0, 1'b0, 8'd0);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL reset_values: got %h expected %h", obs, expv); end
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      obs = obs_vec(); expv = exp_vec(1'b0, 2'd0, 4'd0, 1'b0, 8'd0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_idle cyc%0d: got %h expected %h", c, obs, expv); end
    end
  endtask

  task automatic test_single_producer();
    pulse_reset();
    @(negedge clk);
    req_valid = 4'b0100; set_data(2, 8'h10);
    #1;
    obs = obs_vec(); expv = exp_vec(1'b0, 2'd0, 4'd0, 1'b0, 8'd0);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL single_arb_latency: got %h expected %h", obs, expv); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      set_data(2, 8'(8'h10 + b));
      #1;
      obs = obs_vec(); expv = exp_vec(1'b1, 2'd2, 4'b0100, 1'b1, 8'(8'h10 + b));
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL single_beat%0d: got %h expected %h", b, obs, expv); end
    end
    @(negedge clk);
    set_data(2, 8'h14);
    #1;
    obs = obs_vec(); expv = exp_vec(1'b0, 2'd0, 4'd0, 1'b0, 8'd0);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL single_bubble: got %h expected %h", obs, expv); end
    @(negedge clk);
    #1;
    obs = obs_vec(); expv = exp_vec(1'b1, 2'd2, 4'b0100, 1'b1, 8'h14);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL single_regrant: got %h expected %h", obs, expv); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    obs = obs_vec(); expv = exp_vec(1'b1, 2'd2, 4'b0100, 1'b0, 8'h14);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL single_idle_hold: got %h expected %h", obs, expv); end
    @(negedge clk);
    #1;
    obs = obs_vec(); expv = exp_vec(1'b0, 2'd0, 4'd0, 1'b0, 8'd0);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL single_idle_release: got %h expected %h", obs, expv); end
  endtask

  task automatic test_round_robin();
    logic [7:0] pd [4];
    int g;
    for (int i = 0; i < 4; i++) pd[i] = 8'(i * 64);
    pulse_reset();
    for (int n = 0; n < 5; n++) begin
      g = n % 4;
      @(negedge clk);
      req_valid = 4'hf;
      for (int i = 0; i < 4; i++) set_data(i, pd[i]);
      #1;
      obs = obs_vec(); expv = exp_vec(1'b0, 2'd0, 4'd0, 1'b0, 8'd0);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL rr_bubble%0d: got %h expected %h", n, obs, expv); end
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        set_data(g, pd[g]);
        #1;
        obs = obs_vec(); expv = exp_vec(1'b1, 2'(g), 4'(1 << g), 1'b1, pd[g]);
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL rr_grant%0d_beat%0d: got %h expected %h", n, b, obs, expv); end
        pd[g] = pd[g] + 8'd1;
      end
    end
    req_valid = '0;
  endtask

  task automatic test_full_stall();
    pulse_reset();
    @(negedge clk);
    req_valid = 4'b0010; set_data(1, 8'h20);
    #1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      set_data(1, 8'(8'h20 + b));
      #1;
      obs = obs_vec(); expv = exp_vec(1'b1, 2'd1, 4'b0010, 1'b1, 8'(8'h20 + b));
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL stall_pre_beat%0d: got %h expected %h", b, obs, expv); end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      set_data(1, 8'h22); fifo_full = 1'b1;
      #1;
      obs = obs_vec(); expv = exp_vec(1'b1, 2'd1, 4'b0000, 1'b0, 8'h22);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL stall_cyc%0d: got %h expected %h", c, obs, expv); end
    end
    for (int b = 2; b < 4; b++) begin
      @(negedge clk);
      fifo_full = 1'b0; set_data(1, 8'(8'h20 + b));
      #1;
      obs = obs_vec(); expv = exp_vec(1'b1, 2'd1, 4'b0010, 1'b1, 8'(8'h20 + b));
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL stall_post_beat%0d: got %h expected %h", b, obs, expv); end
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    obs = obs_vec(); expv = exp_vec(1'b0, 2'd0, 4'd0, 1'b0, 8'd0);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL stall_release: got %h expected %h", obs, expv); end
  endtask

  task automatic test_valid_drop();
    pulse_reset();
    @(negedge clk);
    req_valid = 4'b1000; set_data(3, 8'h30); set_data(0, 8'hA0);
    #1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      set_data(3, 8'(8'h30 + b));
      if (b == 1) req_valid[0] = 1'b1;
      #1;
      obs = obs_vec(); expv = exp_vec(1'b1, 2'd3, 4'b1000, 1'b1, 8'(8'h30 + b));
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL drop_beat%0d: got %h expected %h", b, obs, expv); end
    end
    @(negedge clk);
    req_valid[3] = 1'b0;
    #1;
    obs = obs_vec(); expv = exp_vec(1'b1, 2'd3, 4'b1000, 1'b0, 8'h31);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL drop_idle_cycle: got %h expected %h", obs, expv); end
    @(negedge clk);
    #1;
    obs = obs_vec(); expv = exp_vec(1'b0, 2'd0, 4'd0, 1'b0, 8'd0);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL drop_bubble: got %h expected %h", obs, expv); end
    @(negedge clk);
    #1;
    obs = obs_vec(); expv = exp_vec(1'b1, 2'd0, 4'b0001, 1'b1, 8'hA0);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL drop_next_grant: got %h expected %h", obs, expv); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    pulse_reset();
    @(negedge clk);
    req_valid = 4'b0010; set_data(1, 8'h50); set_data(0, 8'h60);
    #1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      set_data(1, 8'(8'h50 + b));
      #1;
      obs = obs_vec(); expv = exp_vec(1'b1, 2'd1, 4'b0010, 1'b1, 8'(8'h50 + b));
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL rstmid_beat%0d: got %h expected %h", b, obs, expv); end
    end
    @(negedge clk);
    set_data(1, 8'h52);
    rstn = 1'b0;
    #1;
    obs = obs_vec(); expv = exp_vec(1'b0, 2'd0, 4'd0, 1'b0, 8'd0);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL rstmid_async: got %h expected %h", obs, expv); end
    req_valid = 4'b0011;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    obs = obs_vec(); expv = exp_vec(1'b0, 2'd0, 4'd0, 1'b0, 8'd0);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL rstmid_idle: got %h expected %h", obs, expv); end
    @(negedge clk);
    #1;
    obs = obs_vec(); expv = exp_vec(1'b1, 2'd0, 4'b0001, 1'b1, 8'h60);
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL rstmid_first_winner: got %h expected %h", obs, expv); end
    req_valid = '0;
  endtask

  // Random producers and back-pressure against a transaction-level model:
  // owner (-1 when the port is free), beats taken this grant, last released.
  task automatic test_random();
    int         m_owner;
    int         m_beats;
    int         m_last;
    int         idx;
    logic [3:0] moved;
    logic       wen;
    m_owner = -1;
    m_beats = 0;
    m_last  = NREQ - 1;
    moved   = '0;
    pulse_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) begin
        // A producer with a pending beat keeps valid and data stable.
        if (!(req_valid[i] && !moved[i])) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_data(i, 8'($urandom));
        end
      end
      #1;
      if (m_owner < 0) begin
        expv = exp_vec(1'b0, 2'd0, 4'd0, 1'b0, 8'd0);
      end else begin
        wen  = req_valid[m_owner] && !fifo_full;
        expv = exp_vec(1'b1, 2'(m_owner), (fifo_full ? 4'd0 : 4'(1 << m_owner)),
                       wen, req_data[m_owner*8 +: 8]);
      end
      obs = obs_vec();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random cyc%0d: got %h expected %h", cyc, obs, expv); end
      moved = '0;
      if (m_owner < 0) begin
        for (int k = 1; k <= 4; k++) begin
          idx = (m_last + k) % 4;
          if (m_owner < 0 && req_valid[idx]) begin
            m_owner = idx;
            m_beats = 0;
          end
        end
      end else if (!req_valid[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (!fifo_full) begin
        moved[m_owner] = 1'b1;
        m_beats++;
        if (m_beats == BURST) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
    req_valid = '0;
    fifo_full = 1'b0;
  endtask

  initial begin
    clk       = 1'b0;
    rstn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    errors    = 0;
    checks    = 0;
    test_reset();
    test_single_producer();
    test_round_robin();
    test_full_stall();
    test_valid_drop();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the write port of one syn_fifo instance between NUM_REQ independent producers.
- Arbitration is round-robin with burst hold: a granted producer keeps the port for up to MAX_BURST accepted beats, then yields.
- Sits directly in front of the FIFO. It drives w_en/w_data from the winner and back-pressures producers with the FIFO full flag.

Parameters:
- NUM_REQ, 4, number of producers; must be at least 2.
- WIDTH, 8, data width; equals the FIFO WIDTH.
- MAX_BURST, 4, maximum beats accepted per grant; must be at least 1.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-producer data valid
- req_data  input  NUM_REQ*WIDTH  producer i data in bits [i*WIDTH +: WIDTH]
- req_ready  output  NUM_REQ  per-producer accept
- fifo_full  input  1  FIFO full flag
- fifo_w_en  output  1  FIFO write enable
- fifo_w_data  output  WIDTH  FIFO write data
- grant_valid  output  1  a producer currently holds the port
- grant_id  output  $clog2(NUM_REQ)  index of the holding producer

Behaviour:
- Clock and reset: clk is the clock. rstn is asynchronous and active-low.
- Reset values:
  - state=IDLE, grant_id=0, grant_valid=0, beat_cnt=0.
  - last_grant=NUM_REQ-1, so producer 0 has first priority after reset.
  - req_ready=0, fifo_w_en=0, fifo_w_data=0.
- Outputs are combinational from registered state. When rstn is asserted they drop to 0 immediately, even mid-burst.
- Handshake: a beat transfers in any cycle where req_valid[i] && req_ready[i]. At that edge fifo_w_en=1. Producers hold data stable while valid && !ready.
- IDLE:
  - req_ready=0, fifo_w_en=0, fifo_w_data=0.
  - If any req_valid bit is set, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register that index as grant_id, set grant_valid=1, clear beat_cnt, go to GRANT.
  - Arbitration latency is 1 cycle from valid to grant. No beat is accepted in IDLE.
- GRANT (g = grant_id):
  - req_ready[g] = !fifo_full. All other req_ready bits are 0.
  - fifo_w_en = req_valid[g] && !fifo_full.
  - fifo_w_data = req_data[g] whenever in GRANT.
  - Each transfer increments beat_cnt; the counter is $clog2(MAX_BURST+1) bits.
- Release from GRANT to IDLE, with last_grant=g and grant_valid=0, occurs when either:
  - a transfer happens with beat_cnt==MAX_BURST-1, so the burst limit is reached on that beat; or
  - req_valid[g]==0 in a GRANT cycle, meaning the producer has idled.
  - There is always exactly one IDLE bubble cycle between grants.
- fifo_full stall: with req_valid[g]=1 and fifo_full=1, the grant is held, beat_cnt is unchanged, and no write occurs. There is no timeout.
- The FIFO full flag is therefore never violated: fifo_w_en is never asserted while fifo_full=1.
- Fairness: after releasing g, g has lowest priority at the next arbitration. A producer that is continuously valid is granted within NUM_REQ arbitrations.
- MAX_BURST=1: every grant carries exactly one beat.
- Simultaneous events: a valid drop on another producer during GRANT has no effect. The burst-limit release and the transfer happen on the same edge.
- Reset mid-burst: any beat not yet accepted is the producer's responsibility. The FIFO resets on the same rstn.

Decomposition:
- Package fifo_arb_pkg contains:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - a function rr_next(valid, last) returning the round-robin winner index.
- One combinational sub-module, rr_pick: inputs req vector and last index; outputs winner index and any_valid. It is instantiated once in fifo_wr_arbiter.

Test Plan:
1. Post-reset, all req_valid=0 for 5 cycles -> grant_valid=0, fifo_w_en=0 every cycle, all req_ready=0.
2. Only producer 2 valid with data 0x10,0x11,... and fifo_full=0 -> grant_id=2 one cycle later. Exactly 4 writes 0x10..0x13 go out on consecutive cycles, then 1 IDLE cycle, then a re-grant to 2 and 0x14 is written.
3. All 4 producers continuously valid -> grant order is 0,1,2,3,0 with 4 beats each. fifo_w_data carries each producer's data in order with no mixing.
4. Producer 1 granted, fifo_full asserted after beat 2 for 6 cycles -> no fifo_w_en and req_ready[1]=0 during the stall. Beats 3 and 4 follow once full clears, then release.
5. Producer 3 drops valid after 2 beats -> release the next cycle, last_grant=3. A pending producer 0 is granted next.
6. rstn asserted mid-burst of producer 1 -> fifo_w_en, req_ready and grant_valid are 0 asynchronously. After release of reset, producer 0 wins if both 0 and 1 are valid.
